i2c_apb_slave: RTL and testbench
================================

// Module: i2c_apb_slave
// PURPOSE
// - APB register front-end of the I2C controller. Decodes APB accesses to the control, target-address and
//   clock-divider registers, the TX/RX data FIFOs and a read-only status register.
// - Hands TX bytes to the I2C core, accepts RX bytes from it and raises i2c_interrupt.
// - Single pclk domain. scl is a sampled input, synchronised and edge-detected internally; it is not a clock.
// PARAMETERS
// - FIFO_DEPTH    8   entries per data FIFO (power of 2, >=4)
// - CLK_DIV_RST   0   reset value of clk_out
// PORTS
// - pclk            in   1   system clock
// - n_rst           in   1   asynchronous active-low reset
// - pdata           in   32  APB write data
// - paddr           in   32  APB byte address; only paddr[4:2] is decoded
// - psel/penable    in   1   APB select / enable
// - pwrite          in   1   APB direction (1 = write)
// - rx_data         in   8   byte from I2C core
// - rx_w_ena        in   1   RX push request, qualified by an scl rising edge
// - i2c_status      in   6   live core status flags
// - scl             in   1   I2C bus clock, sampled
// - tx_r_ena        in   1   TX pop request, qualified by an scl rising edge
// - prdata          out  32  APB read data
// - i2c_interrupt   out  1   interrupt request
// - tx_data         out  8   head of TX FIFO (show-ahead); 0 when empty
// - rx_full         out  1   RX FIFO full
// - rx_almost_full  out  1   RX FIFO count >= FIFO_DEPTH-1
// - control         out  9   control register
// - address         out  10  I2C target-address register
// - clk_out         out  32  clock-divider register
// BEHAVIOUR
// - Reset: every register, FIFO pointer/count, prdata, tx_data, control, address and status flag is 0;
//   clk_out = CLK_DIV_RST.
// - APB protocol:
//   - setup = psel & !penable. At setup, pwrite is captured and prdata is loaded with the addressed
//     read value, so prdata is valid in the access cycle.
//   - prdata holds its value until the next read setup.
//   - access = psel & penable. Write side effects use the pwrite captured at setup; they commit at the
//     access edge. No wait states.
// - Map (paddr[4:2]):
//   - 0 TX FIFO  (W: push pdata[7:0])
//   - 1 control  (RW, [8:0])
//   - 2 address  (RW, [9:0])
//   - 3 RX FIFO  (R: pop)
//   - 4 status   (R)
//   - 5 clk_out  (RW, 32b)
//   - 6-7: reads 0, writes ignored
//   - Register reads zero-extend to 32 bits.
// - FIFO boundaries:
//   - TX push when full: data dropped.
//   - RX pop: happens in the access cycle; data was captured at setup. RX read when empty returns 0 and
//     does not pop.
//   - Simultaneous push and pop on one FIFO: both happen, count unchanged.
// - scl handling: 2-flop synchroniser, then scl_rise = sync & !sync_d.
//   - TX pops when tx_r_ena & scl_rise & !tx_empty.
//   - RX pushes rx_data when rx_w_ena & scl_rise & !rx_full; a push when full is dropped.
// - status[12:0]:
//   - [5:0] i2c_status (registered each pclk)
//   - [6] i2c_interrupt
//   - [7] tx_empty, [8] tx_full, [9] tx_almost_full
//   - [10] rx_empty, [11] rx_full, [12] rx_almost_full
// - i2c_interrupt = |status[5:3], combinational from the registered status.
// CONFIGURATION
// - I2C_IRQ_MASK_EN defined: i2c_interrupt = control[8] & |status[5:3].
// - I2C_IRQ_MASK_EN undefined: no masking; control[8] is plain storage.
// STRUCTURE
// - Package i2c_apb_pkg: register offset enum, status bit index localparams, width constants.
// - Sub-module i2c_reg_fifo (sync FIFO: push, pop, rdata, empty, full, almost_full, count);
//   instantiated twice, for TX and RX.
// TESTING
// - Reset held 4 cycles -> all outputs 0; status read returns 13'b0010010000000 (both FIFOs empty).
// - Write 0xA5 @0x00, then tx_r_ena across an scl rise -> tx_data = 0xA5, then 0; status[7] returns to 1.
// - Write 4 @0x04, 3 @0x08, 18 @0x14 -> control = 4, address = 3, clk_out = 18; read-back matches.
// - rx_data = 4 with rx_w_ena across an scl rise, then read @0x0C -> prdata = 4; RX empty afterwards.
// - i2c_status = 6, read @0x10 -> 13'b0010010000110, irq 0.
//   i2c_status = 6'h3F -> status = 13'b0010011111111, irq 1 (macro off).
// - Push FIFO_DEPTH+1 TX bytes -> full = 1, extra byte dropped; read empty RX -> prdata = 0, no underflow.

Source files
------------

// File: rtl/i2c_apb_pkg.sv
// rtl/i2c_apb_pkg.sv - register map, status bit positions and widths for the I2C APB front-end
package i2c_apb_pkg;

    localparam int APB_DW   = 32;
    localparam int CTRL_W   = 9;
    localparam int ADDR_W   = 10;
    localparam int I2C_ST_W = 6;
    localparam int STATUS_W = 13;

    // Word offsets decoded from paddr[4:2]
    typedef enum logic [2:0] {
        REG_TXF    = 3'd0,
        REG_CTRL   = 3'd1,
        REG_ADDR   = 3'd2,
        REG_RXF    = 3'd3,
        REG_STAT   = 3'd4,
        REG_CLKDIV = 3'd5,
        REG_RSV6   = 3'd6,
        REG_RSV7   = 3'd7
    } reg_off_e;

    // Status register bit positions above the live core flags
    localparam int ST_IRQ      = 6;
    localparam int ST_TX_EMPTY = 7;
    localparam int ST_TX_FULL  = 8;
    localparam int ST_TX_AFULL = 9;
    localparam int ST_RX_EMPTY = 10;
    localparam int ST_RX_FULL  = 11;
    localparam int ST_RX_AFULL = 12;

endpackage

// File: rtl/i2c_apb_slave_if.sv
// rtl/i2c_apb_slave_if.sv - APB bus bundle between host and the I2C register front-end
interface i2c_apb_slave_if;
    import i2c_apb_pkg::*;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_DW-1:0] paddr;
    logic [APB_DW-1:0] pdata;
    logic [APB_DW-1:0] prdata;

    modport master (output psel, output penable, output pwrite, output paddr, output pdata, input prdata);
    modport slave  (input psel, input penable, input pwrite, input paddr, input pdata, output prdata);
endinterface

// File: rtl/i2c_reg_fifo.sv
// rtl/i2c_reg_fifo.sv - synchronous show-ahead FIFO; push when full and pop when empty are ignored
module i2c_reg_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             pclk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push     = push & ~full;
    assign do_pop      = pop & ~empty;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(DEPTH - 1));
    assign rdata       = mem_q[rd_ptr_q];
    assign count       = count_q;

    // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2c_apb_slave.sv
// rtl/i2c_apb_slave.sv - APB register front-end of the I2C controller; optional I2C_IRQ_MASK_EN gates the irq with control[8]
module i2c_apb_slave
    import i2c_apb_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] CLK_DIV_RST = '0
) (
    input  logic                pclk,
    input  logic                n_rst,
    i2c_apb_slave_if.slave      apb,
    input  logic [7:0]          rx_data,
    input  logic                rx_w_ena,
    input  logic [I2C_ST_W-1:0] i2c_status,
    input  logic                scl,
    input  logic                tx_r_ena,
    output logic                i2c_interrupt,
    output logic [7:0]          tx_data,
    output logic                rx_full,
    output logic                rx_almost_full,
    output logic [CTRL_W-1:0]   control,
    output logic [ADDR_W-1:0]   address,
    output logic [APB_DW-1:0]   clk_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    reg_off_e            off;
    logic                setup, access, wr_access;
    logic                pwrite_q, pwrite_d;
    logic                rx_pop_pend_q, rx_pop_pend_d;
    logic [APB_DW-1:0]   prdata_q, prdata_d, rd_val;
    logic [CTRL_W-1:0]   control_q, control_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [APB_DW-1:0]   clk_out_q, clk_out_d;
    logic [I2C_ST_W-1:0] i2c_st_q;
    logic [STATUS_W-1:0] status;
    logic [1:0]          scl_sync_q;
    logic                scl_prev_q, scl_rise;
    logic                tx_push, tx_pop, tx_empty, tx_full, tx_afull;
    logic                rx_push, rx_pop, rx_empty;
    logic [7:0]          tx_rdata, rx_rdata;
    logic [CNT_W-1:0]    tx_count_unused, rx_count_unused;
    logic                unused_bits;

    assign off       = reg_off_e'(apb.paddr[4:2]);
    assign setup     = apb.psel & ~apb.penable;
    assign access    = apb.psel & apb.penable;
    assign wr_access = access & pwrite_q;
    assign scl_rise  = scl_sync_q[1] & ~scl_prev_q;

    assign tx_push = wr_access & (off == REG_TXF);
    assign tx_pop  = tx_r_ena & scl_rise;
    assign rx_push = rx_w_ena & scl_rise;
    assign rx_pop  = access & rx_pop_pend_q;

    assign unused_bits = ^{apb.paddr[31:5], apb.paddr[1:0]};

    i2c_reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .pclk(pclk), .n_rst(n_rst), .push(tx_push), .wdata(apb.pdata[7:0]), .pop(tx_pop),
        .rdata(tx_rdata), .empty(tx_empty), .full(tx_full), .almost_full(tx_afull), .count(tx_count_unused)
    );

    i2c_reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .pclk(pclk), .n_rst(n_rst), .push(rx_push), .wdata(rx_data), .pop(rx_pop),
        .rdata(rx_rdata), .empty(rx_empty), .full(rx_full), .almost_full(rx_almost_full), .count(rx_count_unused)
    );

`ifdef I2C_IRQ_MASK_EN
    assign i2c_interrupt = control_q[CTRL_W-1] & (|i2c_st_q[5:3]);
`else
    assign i2c_interrupt = |i2c_st_q[5:3];
`endif

    // Status word: registered core flags plus live FIFO state
    always_comb begin
        status                 = '0;
        status[I2C_ST_W-1:0]   = i2c_st_q;
        status[ST_IRQ]         = i2c_interrupt;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_AFULL]    = tx_afull;
        status[ST_RX_EMPTY]    = rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_RX_AFULL]    = rx_almost_full;
    end

    // Read mux; an empty RX FIFO reads as zero rather than stale storage
    always_comb begin
        rd_val = '0;
        case (off)
            REG_CTRL:   rd_val = APB_DW'(control_q);
            REG_ADDR:   rd_val = APB_DW'(address_q);
            REG_RXF:    rd_val = rx_empty ? '0 : APB_DW'(rx_rdata);
            REG_STAT:   rd_val = APB_DW'(status);
            REG_CLKDIV: rd_val = clk_out_q;
            default:    rd_val = '0;
        endcase
    end

    // Next-state of the APB-visible registers: capture at setup, commit writes at access
    always_comb begin
        pwrite_d      = pwrite_q;
        prdata_d      = prdata_q;
        rx_pop_pend_d = rx_pop_pend_q;
        control_d     = control_q;
        address_d     = address_q;
        clk_out_d     = clk_out_q;
        if (setup) begin
            pwrite_d      = apb.pwrite;
            rx_pop_pend_d = ~apb.pwrite & (off == REG_RXF) & ~rx_empty;
            if (!apb.pwrite) prdata_d = rd_val;
        end
        if (access) rx_pop_pend_d = 1'b0;
        if (wr_access) begin
            case (off)
                REG_CTRL:   control_d = apb.pdata[CTRL_W-1:0];
                REG_ADDR:   address_d = apb.pdata[ADDR_W-1:0];
                REG_CLKDIV: clk_out_d = apb.pdata;
                default:    ;
            endcase
        end
    end

    // Register state, scl synchroniser and core status sampling
    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            pwrite_q      <= 1'b0;
            prdata_q      <= '0;
            rx_pop_pend_q <= 1'b0;
            control_q     <= '0;
            address_q     <= '0;
            clk_out_q     <= CLK_DIV_RST;
            i2c_st_q      <= '0;
            scl_sync_q    <= '0;
            scl_prev_q    <= 1'b0;
        end else begin
            pwrite_q      <= pwrite_d;
            prdata_q      <= prdata_d;
            rx_pop_pend_q <= rx_pop_pend_d;
            control_q     <= control_d;
            address_q     <= address_d;
            clk_out_q     <= clk_out_d;
            i2c_st_q      <= i2c_status;
            scl_sync_q    <= {scl_sync_q[0], scl};
            scl_prev_q    <= scl_sync_q[1];
        end
    end

    assign apb.prdata = prdata_q;
    assign tx_data    = tx_empty ? 8'h00 : tx_rdata;
    assign control    = control_q;
    assign address    = address_q;
    assign clk_out    = clk_out_q;

endmodule

// File: tb/tb_i2c_apb_slave.sv
// tb/tb_i2c_apb_slave.sv - scoreboard bench for i2c_apb_slave
module tb_i2c_apb_slave;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        pclk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_w_ena = 1'b0;
    logic [5:0]  i2c_status = '0;
    logic        scl = 1'b0;
    logic        tx_r_ena = 1'b0;
    logic        i2c_interrupt, rx_full, rx_almost_full;
    logic [7:0]  tx_data;
    logic [8:0]  control;
    logic [9:0]  address;
    logic [31:0] clk_out;

    logic        chk_stb = 1'b0;
    int          chk_sel = 0;
    exp_t        sb[$];
    int          ncmp = 0;
    int          nerr = 0;

    i2c_apb_slave_if apb ();

    i2c_apb_slave #(.FIFO_DEPTH(8), .CLK_DIV_RST(32'd0)) dut (
        .pclk(pclk), .n_rst(n_rst), .apb(apb),
        .rx_data(rx_data), .rx_w_ena(rx_w_ena), .i2c_status(i2c_status), .scl(scl), .tx_r_ena(tx_r_ena),
        .i2c_interrupt(i2c_interrupt), .tx_data(tx_data), .rx_full(rx_full), .rx_almost_full(rx_almost_full),
        .control(control), .address(address), .clk_out(clk_out)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", ncmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] port_val(int sel);
        case (sel)
            0:       return {24'b0, tx_data};
            1:       return {31'b0, rx_full};
            2:       return {31'b0, rx_almost_full};
            3:       return {23'b0, control};
            4:       return {22'b0, address};
            5:       return clk_out;
            default: return {31'b0, i2c_interrupt};
        endcase
    endfunction

    task automatic compare(logic [31:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            nerr++;
            ncmp++;
            $display("FAIL unexpected_output: got 0x%08h with no expectation queued", act);
        end else begin
            e = sb.pop_front();
            ncmp++;
            if (act !== e.val) begin
                nerr++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
            end
        end
    endtask

    // Monitor: APB read data during access, and port snapshots on request
    always @(negedge pclk) begin
        if (n_rst && apb.psel && apb.penable && !apb.pwrite) compare(apb.prdata);
        if (chk_stb) compare(port_val(chk_sel));
    end

    task automatic expect_val(string name, logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic apb_write(logic [31:0] addr, logic [31:0] data);
        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = addr; apb.pdata = data;
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        @(posedge pclk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic apb_read(logic [31:0] addr, logic [31:0] exp, string name);
        expect_val(name, exp);
        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        @(posedge pclk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic check_port(int sel, logic [31:0] exp, string name);
        expect_val(name, exp);
        @(posedge pclk); #1;
        chk_sel = sel;
        chk_stb = 1'b1;
        @(posedge pclk); #1;
        chk_stb = 1'b0;
    endtask

    task automatic scl_pulse();
        @(posedge pclk); #1;
        scl = 1'b1;
        repeat (4) @(posedge pclk);
        #1 scl = 1'b0;
        repeat (4) @(posedge pclk);
    endtask

    initial begin
        logic [31:0] st_all_hi;
        logic [31:0] irq_all_hi;
`ifdef I2C_IRQ_MASK_EN
        st_all_hi  = 32'h04BF;
        irq_all_hi = 32'd0;
`else
        st_all_hi  = 32'h04FF;
        irq_all_hi = 32'd1;
`endif
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pdata = '0;
        repeat (4) @(posedge pclk);
        #1 n_rst = 1'b1;

        // Reset state
        check_port(0, 32'h00, "rst_tx_data");
        check_port(1, 32'h0, "rst_rx_full");
        check_port(2, 32'h0, "rst_rx_afull");
        check_port(3, 32'h0, "rst_control");
        check_port(4, 32'h0, "rst_address");
        check_port(5, 32'h0, "rst_clk_out");
        check_port(6, 32'h0, "rst_irq");
        apb_read(32'h10, 32'h0480, "rst_status");

        // Single TX byte out through an scl rise
        apb_write(32'h00, 32'h000000A5);
        check_port(0, 32'hA5, "tx_head_a5");
        apb_read(32'h10, 32'h0400, "status_tx_nonempty");
        tx_r_ena = 1'b1;
        scl_pulse();
        tx_r_ena = 1'b0;
        check_port(0, 32'h00, "tx_after_pop");
        apb_read(32'h10, 32'h0480, "status_tx_empty_again");

        // Register writes and read-back
        apb_write(32'h04, 32'd4);
        apb_write(32'h08, 32'd3);
        apb_write(32'h14, 32'd18);
        check_port(3, 32'd4, "control_port");
        check_port(4, 32'd3, "address_port");
        check_port(5, 32'd18, "clk_out_port");
        apb_read(32'h04, 32'd4, "control_rd");
        apb_read(32'h08, 32'd3, "address_rd");
        apb_read(32'h14, 32'd18, "clk_out_rd");
        apb_write(32'h04, 32'hFFFF_FFFF);
        apb_read(32'h04, 32'h1FF, "control_zero_ext");
        apb_write(32'h04, 32'd4);

        // Single RX byte in, then popped by a read
        rx_data = 8'd4; rx_w_ena = 1'b1;
        scl_pulse();
        rx_w_ena = 1'b0;
        apb_read(32'h10, 32'h0080, "status_rx_nonempty");
        apb_read(32'h0C, 32'd4, "rx_pop_4");
        apb_read(32'h10, 32'h0480, "status_rx_empty_again");

        // Core status flags and interrupt
        i2c_status = 6'd6;
        apb_read(32'h10, 32'h0486, "status_core6");
        check_port(6, 32'd0, "irq_core6");
        i2c_status = 6'h3F;
        apb_read(32'h10, st_all_hi, "status_core3f");
        check_port(6, irq_all_hi, "irq_core3f");
        i2c_status = 6'd0;

        // TX overflow: ninth byte dropped, drain shows the first eight in order
        for (int i = 0; i < 9; i++) apb_write(32'h00, 32'h10 + i);
        check_port(0, 32'h10, "tx_full_head");
        apb_read(32'h10, 32'h0700, "status_tx_full");
        tx_r_ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            scl_pulse();
            check_port(0, (i < 7) ? 32'h11 + i : 32'h00, "tx_drain");
        end
        tx_r_ena = 1'b0;
        apb_read(32'h10, 32'h0480, "status_tx_drained");

        // RX fill to full, overflow dropped, drain, underflow reads 0
        rx_w_ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h20 + 8'(i);
            scl_pulse();
            if (i == 6) begin
                check_port(2, 32'd1, "rx_afull_at_7");
                check_port(1, 32'd0, "rx_not_full_at_7");
            end
        end
        check_port(1, 32'd1, "rx_full_at_8");
        rx_data = 8'h99;
        scl_pulse();
        rx_w_ena = 1'b0;
        apb_read(32'h10, 32'h1880, "status_rx_full");
        for (int i = 0; i < 8; i++) apb_read(32'h0C, 32'h20 + i, "rx_drain");
        apb_read(32'h0C, 32'h0, "rx_underflow");
        apb_read(32'h10, 32'h0480, "status_rx_drained");
        check_port(1, 32'd0, "rx_full_cleared");

        // Unmapped offsets and write-only TX read
        apb_write(32'h18, 32'hDEADBEEF);
        apb_read(32'h18, 32'h0, "rsv6_rd");
        apb_read(32'h1C, 32'h0, "rsv7_rd");
        apb_read(32'h00, 32'h0, "txf_rd");
        check_port(3, 32'd4, "control_unchanged");

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge pclk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            ncmp++;
            nerr++;
            $display("FAIL %s: no output observed, expected 0x%08h", e.name, e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
